// File: rtl/ir_fan_pkg.sv
// ir_fan_pkg: shared types and defaults for the IR-remote fan controller.
// Holds the FSM state enum, the speed-level type, the captured-frame layout,
// the default NEC command bytes and the off-timer preset lookup.
package ir_fan_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_SPINUP = 2'd1,
      ST_RUN    = 2'd2
   } fan_state_t;

   typedef logic [1:0] level_t;

   // Only the address and command bytes of an NEC frame matter downstream.
   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] cmd;
      logic [7:0] cmd_n;
   } frame_t;

   localparam logic [7:0] DEF_CMD_POWER = 8'h45;
   localparam logic [7:0] DEF_CMD_UP    = 8'h46;
   localparam logic [7:0] DEF_CMD_DOWN  = 8'h15;
   localparam logic [7:0] DEF_CMD_TIMER = 8'h44;

   localparam level_t LEVEL_MIN = 2'd1;
   localparam level_t LEVEL_MAX = 2'd3;

   // Countdown width in timer units; the longest preset is 5400.
   localparam int unsigned TIMER_W = 13;

   // Bits needed for a counter that runs 0..n-1 (never less than one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Off-timer preset in timer units for a given selection (0 = no timer).
   function automatic logic [TIMER_W-1:0] timer_preset(input logic [1:0] sel);
      case (sel)
         2'd1:    return TIMER_W'(1800);
         2'd2:    return TIMER_W'(3600);
         2'd3:    return TIMER_W'(5400);
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/ir_fan_ctrl_if.sv
// ir_fan_ctrl_if: link between the IR decoder (master) and the fan
// controller (slave). The decoder provides the frame word; the controller
// returns the PWM drive and the LED status signals.
interface ir_fan_ctrl_if;
   import ir_fan_pkg::*;

   logic [31:0] ir_data;
   logic        fan_pwm;
   logic        power_on;
   level_t      speed_level;
   logic [1:0]  timer_sel;
   logic        cmd_strobe;
   logic        frame_err;

   modport master (
      output ir_data,
      input  fan_pwm, power_on, speed_level, timer_sel, cmd_strobe, frame_err
   );

   modport slave (
      input  ir_data,
      output fan_pwm, power_on, speed_level, timer_sel, cmd_strobe, frame_err
   );

endinterface

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: fixed-period PWM with a duty register that only reloads at the
// last count of a period, so a duty change never produces a runt or stretched
// pulse. i_force_off drops the output on the next cycle and clears the duty.
module fan_pwm_gen #(
   parameter int unsigned PWM_PERIOD = 4000,
   parameter int unsigned W          = $clog2(PWM_PERIOD + 1)
) (
   input  logic         clk,
   input  logic         reset_p,
   input  logic [W-1:0] i_target,
   input  logic         i_force_off,
   output logic         o_pwm
);

   localparam logic [W-1:0] CNT_LAST = W'(PWM_PERIOD - 1);

   logic [W-1:0] r_cnt;
   logic [W-1:0] r_active_duty;
   logic         r_pwm;

   // Period counter, boundary-loaded duty and registered output.
   // NOTE: state updates use non-blocking (<=) so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_cnt         <= '0;
         r_active_duty <= '0;
         r_pwm         <= 1'b0;
      end else begin
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         if (i_force_off) begin
            r_active_duty <= '0;
            r_pwm         <= 1'b0;
         end else begin
            r_pwm <= (r_cnt < r_active_duty);
            if (r_cnt == CNT_LAST) begin
               r_active_duty <= i_target;
            end
         end
      end
   end

   assign o_pwm = r_pwm;

endmodule

// File: rtl/ir_fan_ctrl.sv
// ir_fan_ctrl: turns NEC remote key presses into fan power/speed control.
// Detects the rising edge of a nonzero frame word, validates address and
// command complement, runs an OFF/SPINUP/RUN state machine and drives a PWM
// generator. Optional off-timer is built when IR_FAN_TIMER_EN is defined.
module ir_fan_ctrl
   import ir_fan_pkg::*;
#(
   parameter int unsigned PWM_PERIOD    = 4000,
   parameter int unsigned DUTY1         = 1600,
   parameter int unsigned DUTY2         = 2800,
   parameter int unsigned DUTY3         = 4000,
   parameter int unsigned SPINUP_CYCLES = 50_000_000,
   parameter logic [7:0]  ADDR          = 8'h00,
   parameter logic [7:0]  CMD_POWER     = DEF_CMD_POWER,
   parameter logic [7:0]  CMD_UP        = DEF_CMD_UP,
   parameter logic [7:0]  CMD_DOWN      = DEF_CMD_DOWN
`ifdef IR_FAN_TIMER_EN
   ,
   parameter logic [7:0]  CMD_TIMER         = DEF_CMD_TIMER,
   parameter int unsigned TIMER_UNIT_CYCLES = 100_000_000
`endif
) (
   input  logic           clk,
   input  logic           reset_p,
   ir_fan_ctrl_if.slave   bus
);

   localparam int unsigned DUTY_W = cnt_width(PWM_PERIOD + 1);
   localparam int unsigned SPIN_W = cnt_width(SPINUP_CYCLES);
   localparam logic [SPIN_W-1:0] SPIN_LAST = SPIN_W'(SPINUP_CYCLES - 1);

   logic              r_prev_nz;
   logic              r_pend;
   frame_t            r_frame;
   fan_state_t        r_state;
   level_t            r_level;
   level_t            r_speed_level;
   logic              r_power_on;
   logic              r_cmd_strobe;
   logic              r_frame_err;
   logic [SPIN_W-1:0] r_spin_cnt;

   logic              w_new_frame;
   logic              w_valid;
   logic              w_cmd_power;
   logic              w_cmd_up;
   logic              w_cmd_down;
   logic              w_expire;
   level_t            w_level_up;
   level_t            w_level_dn;
   logic [DUTY_W-1:0] w_target;
   logic              w_force_off;
   logic              w_pwm;

`ifdef IR_FAN_TIMER_EN
   localparam int unsigned UNIT_W = cnt_width(TIMER_UNIT_CYCLES);

   logic [1:0]         r_timer_sel;
   logic [TIMER_W-1:0] r_countdown;
   logic [UNIT_W-1:0]  r_unit_cnt;
   logic               w_unit_tick;
   logic               w_cmd_timer;

   assign w_unit_tick = (r_unit_cnt == UNIT_W'(TIMER_UNIT_CYCLES - 1));
   // Expiry fires on the tick that takes the countdown from 1 to 0.
   assign w_expire    = (r_timer_sel != 2'd0) && w_unit_tick &&
                        (r_countdown == TIMER_W'(1));
   assign w_cmd_timer = r_pend && w_valid && (r_frame.cmd == CMD_TIMER);
`else
   assign w_expire = 1'b0;
`endif

   assign w_new_frame = (|bus.ir_data) && !r_prev_nz;

   // Capture a frame on the first nonzero cycle; a held key yields one event.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_prev_nz <= 1'b0;
         r_pend    <= 1'b0;
         r_frame   <= '0;
      end else begin
         r_prev_nz <= |bus.ir_data;
         r_pend    <= w_new_frame;
         if (w_new_frame) begin
            r_frame <= '{addr: bus.ir_data[31:24], cmd: bus.ir_data[15:8],
                         cmd_n: bus.ir_data[7:0]};
         end
      end
   end

   // Validate the pending frame, decode its command and precompute levels.
   // NOTE: every always_comb output gets a value on every path (here
   // unconditionally), otherwise synthesis infers a latch.
   always_comb begin
      w_valid     = (r_frame.cmd == ~r_frame.cmd_n) && (r_frame.addr == ADDR);
      w_cmd_power = r_pend && w_valid && (r_frame.cmd == CMD_POWER);
      w_cmd_up    = r_pend && w_valid && (r_frame.cmd == CMD_UP);
      w_cmd_down  = r_pend && w_valid && (r_frame.cmd == CMD_DOWN);
      w_level_up  = (r_level == LEVEL_MAX) ? LEVEL_MAX : level_t'(r_level + 2'd1);
      w_level_dn  = (r_level == LEVEL_MIN) ? LEVEL_MIN : level_t'(r_level - 2'd1);
   end

   // Power/speed state machine with registered status outputs and off-timer.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_state       <= ST_OFF;
         r_level       <= LEVEL_MIN;
         r_speed_level <= '0;
         r_power_on    <= 1'b0;
         r_cmd_strobe  <= 1'b0;
         r_frame_err   <= 1'b0;
         r_spin_cnt    <= '0;
`ifdef IR_FAN_TIMER_EN
         r_timer_sel   <= 2'd0;
         r_countdown   <= '0;
         r_unit_cnt    <= '0;
`endif
      end else begin
         // The strobe pulses for a valid frame even when expiry discards it.
         r_cmd_strobe <= r_pend && w_valid;
         r_frame_err  <= r_pend && !w_valid;
`ifdef IR_FAN_TIMER_EN
         if (r_timer_sel != 2'd0) begin
            if (w_unit_tick) begin
               r_unit_cnt  <= '0;
               r_countdown <= r_countdown - 1'b1;
            end else begin
               r_unit_cnt <= r_unit_cnt + 1'b1;
            end
         end
`endif
         case (r_state)
            ST_OFF: begin
               if (w_cmd_power) begin
                  r_state       <= ST_SPINUP;
                  r_spin_cnt    <= '0;
                  r_power_on    <= 1'b1;
                  r_speed_level <= r_level;
               end
            end
            ST_SPINUP, ST_RUN: begin
               if (r_state == ST_SPINUP) begin
                  if (r_spin_cnt == SPIN_LAST) begin
                     r_state <= ST_RUN;
                  end else begin
                     r_spin_cnt <= r_spin_cnt + 1'b1;
                  end
               end
               // Turning off overrides spin-up completion and any command.
               if (w_expire || w_cmd_power) begin
                  r_state       <= ST_OFF;
                  r_power_on    <= 1'b0;
                  r_speed_level <= '0;
`ifdef IR_FAN_TIMER_EN
                  r_timer_sel   <= 2'd0;
`endif
               end else if (w_cmd_up) begin
                  r_level       <= w_level_up;
                  r_speed_level <= w_level_up;
               end else if (w_cmd_down) begin
                  r_level       <= w_level_dn;
                  r_speed_level <= w_level_dn;
               end
`ifdef IR_FAN_TIMER_EN
               else if (w_cmd_timer) begin
                  r_timer_sel <= r_timer_sel + 2'd1;
                  r_countdown <= timer_preset(r_timer_sel + 2'd1);
                  r_unit_cnt  <= '0;
               end
`endif
            end
            default: begin
               r_state       <= ST_OFF;
               r_power_on    <= 1'b0;
               r_speed_level <= '0;
            end
         endcase
      end
   end

   // Duty target for the PWM generator from the current state and level.
   always_comb begin
      w_target = '0;
      case (r_state)
         ST_SPINUP: w_target = DUTY_W'(PWM_PERIOD);
         ST_RUN: begin
            case (r_level)
               2'd1:    w_target = DUTY_W'(DUTY1);
               2'd2:    w_target = DUTY_W'(DUTY2);
               default: w_target = DUTY_W'(DUTY3);
            endcase
         end
         default: w_target = '0;
      endcase
   end

   assign w_force_off = (r_state == ST_OFF);

   fan_pwm_gen #(
      .PWM_PERIOD (PWM_PERIOD),
      .W          (DUTY_W)
   ) u_pwm (
      .clk         (clk),
      .reset_p     (reset_p),
      .i_target    (w_target),
      .i_force_off (w_force_off),
      .o_pwm       (w_pwm)
   );

   assign bus.fan_pwm     = w_pwm;
   assign bus.power_on    = r_power_on;
   assign bus.speed_level = r_speed_level;
   assign bus.cmd_strobe  = r_cmd_strobe;
   assign bus.frame_err   = r_frame_err;
`ifdef IR_FAN_TIMER_EN
   assign bus.timer_sel   = r_timer_sel;
`else
   assign bus.timer_sel   = 2'd0;
`endif

endmodule

// File: tb/tb_ir_fan_ctrl.sv
// tb_ir_fan_ctrl: directed plus randomized frames against a cycle-level
// reference model of the fan controller; every output is compared each cycle.
module tb_ir_fan_ctrl;

   localparam int P  = 8;
   localparam int D1 = 2;
   localparam int D2 = 4;
   localparam int D3 = 8;
   localparam int S  = 16;
   localparam int U  = 4;

   localparam logic [31:0] F_POWER = 32'h00FF45BA;
   localparam logic [31:0] F_UP    = 32'h00FF46B9;
   localparam logic [31:0] F_DOWN  = 32'h00FF15EA;
   localparam logic [31:0] F_TIMER = 32'h00FF44BB;
   localparam logic [31:0] F_UNK   = 32'h00FF12ED;
   localparam logic [31:0] F_BAD   = 32'h00FF4545;
   localparam logic [31:0] F_WADDR = 32'h01FE45BA;

   logic clk = 1'b0;
   logic reset_p;

   ir_fan_ctrl_if bus ();

   ir_fan_ctrl #(
      .PWM_PERIOD    (P),
      .DUTY1         (D1),
      .DUTY2         (D2),
      .DUTY3         (D3),
      .SPINUP_CYCLES (S),
      .ADDR          (8'h00)
`ifdef IR_FAN_TIMER_EN
      ,
      .TIMER_UNIT_CYCLES (U)
`endif
   ) dut (
      .clk     (clk),
      .reset_p (reset_p),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_strobe = 0;
   int n_err = 0;
   int n_pwm_hi = 0;

   // Reference model state
   int          m_k;
   int          m_act;
   int          m_level;
   int          m_sel;
   int          m_tleft;
   int          m_spin_left;
   bit          m_on;
   bit          m_spinning;
   bit          m_prev_nz;
   logic [31:0] m_q[$];
   bit          e_pwm;
   bit          e_strobe;
   bit          e_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
         if (errors >= 100) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   endtask

   function automatic int m_target();
      if (!m_on)      return 0;
      if (m_spinning) return P;
      case (m_level)
         1:       return D1;
         2:       return D2;
         default: return D3;
      endcase
   endfunction

   task automatic model_reset();
      m_k = 0; m_act = 0; m_level = 1; m_sel = 0; m_tleft = 0;
      m_spin_left = 0; m_on = 0; m_spinning = 0; m_prev_nz = 0;
      m_q.delete();
      e_pwm = 0; e_strobe = 0; e_err = 0;
   endtask

   task automatic model_off();
      m_on = 0; m_spinning = 0; m_sel = 0;
   endtask

   task automatic model_cmd(input logic [7:0] cmd);
      if (cmd == 8'h45) begin
         if (m_on) model_off();
         else begin
            m_on = 1; m_spinning = 1; m_spin_left = S;
         end
      end else if (cmd == 8'h46 && m_on) begin
         m_level = (m_level >= 3) ? 3 : m_level + 1;
      end else if (cmd == 8'h15 && m_on) begin
         m_level = (m_level <= 1) ? 1 : m_level - 1;
      end
`ifdef IR_FAN_TIMER_EN
      else if (cmd == 8'h44 && m_on) begin
         m_sel   = (m_sel + 1) % 4;
         m_tleft = 1800 * m_sel * U;
      end
`endif
   endtask

   // One clock edge of the specified behaviour, with ir_data as sampled there.
   task automatic model_edge(input logic [31:0] d);
      int          c;
      bit          expire;
      bit          valid;
      logic [31:0] f;
      m_k++;
      c = (m_k - 1) % P;
      if (!m_on) begin
         e_pwm = 0; m_act = 0;
      end else begin
         e_pwm = (c < m_act);
         if (c == P - 1) m_act = m_target();
      end
      e_strobe = 0; e_err = 0;
      expire = (m_sel != 0) && (m_tleft == 1);
      if (m_sel != 0) m_tleft--;
      if (m_on && m_spinning) begin
         if (m_spin_left == 1) m_spinning = 0;
         else m_spin_left--;
      end
      if (m_q.size() > 0) begin
         f = m_q.pop_front();
         valid = (f[31:24] == 8'h00) && (f[15:8] == ~f[7:0]);
         e_strobe = valid;
         e_err = !valid;
         if (valid && !expire) model_cmd(f[15:8]);
      end
      if (expire) model_off();
      if (d != 0 && !m_prev_nz) m_q.push_back(d);
      m_prev_nz = (d != 0);
   endtask

   task automatic step(input logic [31:0] d);
      logic [8:0] obs;
      logic [8:0] exp;
      bus.ir_data = d;
      @(posedge clk);
      model_edge(d);
      #1;
      obs = {bus.fan_pwm, bus.power_on, bus.speed_level, bus.timer_sel,
             bus.cmd_strobe, bus.frame_err};
      exp = {e_pwm, m_on, (m_on ? 2'(m_level) : 2'd0), 2'(m_sel), e_strobe, e_err};
      check("outs", 32'(obs), 32'(exp));
      if (bus.cmd_strobe) n_strobe++;
      if (bus.frame_err) n_err++;
      if (bus.fan_pwm) n_pwm_hi++;
   endtask

   task automatic send(input logic [31:0] f, input int hold, input int gap);
      repeat (hold) step(f);
      repeat (gap) step(32'h0);
   endtask

   task automatic do_reset();
      bus.ir_data = 32'h0;
      reset_p = 1'b1;
      #1;
      check("rst_outs", {bus.fan_pwm, bus.power_on, bus.speed_level, bus.timer_sel,
                         bus.cmd_strobe, bus.frame_err}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_p = 1'b0;
      model_reset();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int e0;
      int n;
      int lv_up[3];
      int lv_dn[3];
      lv_up = '{2, 3, 3};
      lv_dn = '{2, 1, 1};
      reset_p = 1'b0;
      bus.ir_data = 32'h0;
      #2;
      do_reset();

      // 1: held POWER frame -> one strobe, 16 cycles high, then 2-of-8 duty
      s0 = n_strobe;
      n_pwm_hi = 0;
      repeat (40) step(F_POWER);
      check("t1_strobes", n_strobe - s0, 1);
      check("t1_power", bus.power_on, 1);
      check("t1_speed", bus.speed_level, 1);
      check("t1_pwm_high", n_pwm_hi, 20);
      send(32'h0, 0, 10);

      // 2: UP x3 then DOWN x3
      for (int i = 0; i < 3; i++) begin
         send(F_UP, 2, 12);
         check("t2_up", bus.speed_level, lv_up[i]);
      end
      for (int i = 0; i < 3; i++) begin
         send(F_DOWN, 2, 12);
         check("t2_dn", bus.speed_level, lv_dn[i]);
      end

      // 3: corrupt and wrong-address frames
      s0 = n_strobe; e0 = n_err;
      send(F_BAD, 3, 10);
      check("t3_bad_err", n_err - e0, 1);
      check("t3_bad_stb", n_strobe - s0, 0);
      check("t3_bad_pwr", bus.power_on, 1);
      check("t3_bad_spd", bus.speed_level, 1);
      e0 = n_err;
      send(F_WADDR, 2, 10);
      check("t3_addr_err", n_err - e0, 1);

      // 4: reset mid-SPINUP, then restart at level 1
      send(F_UP, 1, 5);
      send(F_UP, 1, 5);
      send(F_POWER, 1, 5);
      check("t4_off", bus.power_on, 0);
      send(F_POWER, 1, 5);
      check("t4_on", bus.power_on, 1);
      do_reset();
      send(F_POWER, 1, 30);
      check("t4_lvl", bus.speed_level, 1);

      // 5: level retained across off/on
      send(F_UP, 1, 5);
      send(F_UP, 1, 5);
      check("t5_lvl3", bus.speed_level, 3);
      send(F_POWER, 1, 10);
      check("t5_off_spd", bus.speed_level, 0);
      send(F_POWER, 1, 25);
      check("t5_back3", bus.speed_level, 3);

`ifdef IR_FAN_TIMER_EN
      // 6: off-timer expiry, then expiry colliding with a pending command
      send(F_TIMER, 1, 4);
      check("t6_sel", bus.timer_sel, 1);
      n = 0;
      while (bus.power_on && n < 8000) begin
         step(32'h0);
         n++;
      end
      check("t6_expiry_cycles", n, 7197);
      step(32'h0);
      check("t6_pwm", bus.fan_pwm, 0);
      check("t6_sel0", bus.timer_sel, 0);
      send(F_POWER, 1, 5);
      send(F_TIMER, 1, 2);
      n = 0;
      while (m_tleft != 2 && n < 8000) begin
         step(32'h0);
         n++;
      end
      check("t6_wait_bound", (n < 8000) ? 1 : 0, 1);
      step(F_UP);
      step(32'h0);
      check("t6_sim_stb", bus.cmd_strobe, 1);
      check("t6_sim_pwr", bus.power_on, 0);
      check("t6_sim_spd", bus.speed_level, 0);
      send(32'h0, 0, 5);
      send(F_POWER, 1, 25);
`else
      // 6: TIMER frame is an unknown command in this build
      s0 = n_strobe;
      send(F_TIMER, 1, 6);
      check("t6_stb", n_strobe - s0, 1);
      check("t6_sel", bus.timer_sel, 0);
      check("t6_spd", bus.speed_level, 3);
      check("t6_pwr", bus.power_on, 1);
`endif

      // Randomized frames checked cycle by cycle against the model
      for (int i = 0; i < 150; i++) begin
         logic [31:0] f;
         logic [7:0]  c;
         c = 8'($urandom);
         case ($urandom_range(0, 9))
            0:       f = F_POWER;
            1, 2:    f = F_UP;
            3, 4:    f = F_DOWN;
            5:       f = F_TIMER;
            6:       f = {8'h00, 8'hFF, c, ~c};
            7:       f = {8'h00, 8'hFF, c, c ^ 8'h5A};
            8:       f = F_WADDR;
            default: f = $urandom;
         endcase
         if ($urandom_range(0, 15) == 0) f = F_UNK;
         send(f, $urandom_range(1, 5), $urandom_range(1, 25));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
